vector_addsub_pipe: RTL and testbench

//  Parametrised vector integer add/subtract functional unit.

---
 rtl/vector_addsub_pipe_if.sv | 31 +++
 rtl/vector_addsub_pipe.sv | 107 ++++++++++
 tb/tb_vector_addsub_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vector_addsub_pipe_if.sv
// vector_addsub_pipe_if: issue, register-file read and write-back signals of the vector add/sub unit
interface vector_addsub_pipe_if #(
  parameter int DATA_W   = 64,
  parameter int VL_W     = 7,
  parameter int NUM_VREG = 8
);
  localparam int RIDX_W = $clog2(NUM_VREG);
  logic                       i_start;
  logic [6:0]                 i_instr;
  logic [RIDX_W-1:0]          i_i;
  logic [RIDX_W-1:0]          i_j;
  logic [RIDX_W-1:0]          i_k;
  logic [VL_W-1:0]            i_vl;
  logic [DATA_W-1:0]          i_sj;
  logic [NUM_VREG*DATA_W-1:0] i_v_rd;
  logic [VL_W-1:0]            o_rd_idx;
  logic [DATA_W-1:0]          o_result;
  logic                       o_wr_valid;
  logic [RIDX_W-1:0]          o_wr_reg;
  logic [VL_W-1:0]            o_wr_idx;
  logic                       o_busy;
  logic                       o_reject;
  modport master (
    output i_start, i_instr, i_i, i_j, i_k, i_vl, i_sj, i_v_rd,
    input  o_rd_idx, o_result, o_wr_valid, o_wr_reg, o_wr_idx, o_busy, o_reject
  );
  modport slave (
    input  i_start, i_instr, i_i, i_j, i_k, i_vl, i_sj, i_v_rd,
    output o_rd_idx, o_result, o_wr_valid, o_wr_reg, o_wr_idx, o_busy, o_reject
  );
endinterface

// File: rtl/vector_addsub_pipe.sv
// vector_addsub_pipe: self-sequencing vector integer add/sub unit with tagged LAT-stage result pipeline
module vector_addsub_pipe #(
  parameter int DATA_W   = 64,
  parameter int VL_W     = 7,
  parameter int NUM_VREG = 8,
  parameter int LAT      = 3
) (
  input logic clk,
  input logic rst,
  vector_addsub_pipe_if.slave bus
);
  localparam int RIDX_W = $clog2(NUM_VREG);
  logic              act;
  logic              rej;
  logic              vec_r;
  logic              sub_r;
  logic [VL_W-1:0]   cnt;
  logic [VL_W-1:0]   vl_r;
  logic [RIDX_W-1:0] i_r;
  logic [RIDX_W-1:0] j_r;
  logic [RIDX_W-1:0] k_r;
  logic [DATA_W-1:0] sj_r;
  logic              vld [LAT];
  logic [VL_W-1:0]   idx [LAT];
  logic [DATA_W-1:0] dat [LAT];
  logic              legal;
  logic              busy;
  logic              accept;
  logic              issue;
  logic              last;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] res;
  // decode, occupancy and the stage-1 add/sub on the element being read this cycle
  always_comb begin
    legal = bus.i_instr[6:2] == 5'b11011;
    busy = act;
    for (int n = 0; n < LAT; n++) busy = busy | vld[n];
    accept = bus.i_start && !busy && legal;
    issue = act && vl_r != '0;
    last = vl_r == '0 || cnt == vl_r - VL_W'(1);
    op_a = vec_r ? bus.i_v_rd[DATA_W*j_r +: DATA_W] : sj_r;
    op_b = bus.i_v_rd[DATA_W*k_r +: DATA_W];
    res = sub_r ? op_a - op_b : op_a + op_b;
  end
  // operation capture and element sequencer; cnt holds its last index once issue ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act <= 1'b0;
      rej <= 1'b0;
      vec_r <= 1'b0;
      sub_r <= 1'b0;
      cnt <= '0;
      vl_r <= '0;
      i_r <= '0;
      j_r <= '0;
      k_r <= '0;
      sj_r <= '0;
    end else begin
      rej <= bus.i_start && !accept;
      if (accept) begin
        act <= 1'b1;
        cnt <= '0;
        vl_r <= bus.i_vl;
        vec_r <= bus.i_instr[0];
        sub_r <= bus.i_instr[1];
        i_r <= bus.i_i;
        j_r <= bus.i_j;
        k_r <= bus.i_k;
        sj_r <= bus.i_sj;
      end else if (act) begin
        act <= !last;
        if (!last) cnt <= cnt + VL_W'(1);
      end
    end
  end
  // result pipeline; idx/data only load on a valid beat so the outputs hold between results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < LAT; n++) begin
        vld[n] <= 1'b0;
        idx[n] <= '0;
        dat[n] <= '0;
      end
    end else begin
      vld[0] <= issue;
      if (issue) begin
        idx[0] <= cnt;
        dat[0] <= res;
      end
      for (int n = 1; n < LAT; n++) begin
        vld[n] <= vld[n-1];
        if (vld[n-1]) begin
          idx[n] <= idx[n-1];
          dat[n] <= dat[n-1];
        end
      end
    end
  end
  assign bus.o_rd_idx   = cnt;
  assign bus.o_result   = dat[LAT-1];
  assign bus.o_wr_valid = vld[LAT-1];
  assign bus.o_wr_reg   = i_r;
  assign bus.o_wr_idx   = idx[LAT-1];
  assign bus.o_busy     = busy;
  assign bus.o_reject   = rej;
endmodule

// File: tb/tb_vector_addsub_pipe.sv
// tb_vector_addsub_pipe: directed table, corner sequences and random ops against a cycle-stamped scoreboard
module tb_vector_addsub_pipe;
  localparam int DATA_W = 64, VL_W = 7, NUM_VREG = 8, LAT = 3, RIDX_W = 3;
  localparam logic [6:0] SADD = 7'b1101100, VADD = 7'b1101101, SSUB = 7'b1101110, VSUB = 7'b1101111;
  typedef struct {int dst; int idx; logic [63:0] data; int due;} exp_t;
  typedef struct {logic [6:0] instr; int i; int j; int k; int vl; logic [63:0] sj; int n; logic [63:0] exp [4];} row_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] vf [NUM_VREG][128];
  exp_t q [$];
  logic [63:0] got [$];
  bit rej_map [int];
  int cyc = 0, busy_lo = 0, busy_hi = -1, total = 0, bad = 0;
  row_t rows [5];
  vector_addsub_pipe_if #(.DATA_W(DATA_W), .VL_W(VL_W), .NUM_VREG(NUM_VREG)) bus ();
  vector_addsub_pipe #(.DATA_W(DATA_W), .VL_W(VL_W), .NUM_VREG(NUM_VREG), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // cycle stamp: during the cycle after edge S, cyc equals S+1 relative to the start cycle
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < NUM_VREG; g++) begin : g_rf
    assign bus.i_v_rd[g*DATA_W +: DATA_W] = vf[g][bus.o_rd_idx];
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic bit model_busy(int c);
    return c >= busy_lo && c <= busy_hi;
  endfunction
  task automatic do_start(logic [6:0] instr, int i, int j, int k, int vl, logic [63:0] sj);
    int c;
    logic [63:0] a, b;
    bit vec, sub;
    @(negedge clk);
    c = cyc;
    bus.i_start = 1'b1;
    bus.i_instr = instr;
    bus.i_i = RIDX_W'(i);
    bus.i_j = RIDX_W'(j);
    bus.i_k = RIDX_W'(k);
    bus.i_vl = VL_W'(vl);
    bus.i_sj = sj;
    vec = instr == VADD || instr == VSUB;
    sub = instr == SSUB || instr == VSUB;
    if (model_busy(c) || !(instr inside {SADD, VADD, SSUB, VSUB})) rej_map[c+1] = 1'b1;
    else begin
      busy_lo = c + 1;
      busy_hi = vl == 0 ? c + 1 : c + vl + LAT;
      for (int e = 0; e < vl; e++) begin
        a = vec ? vf[j][e] : sj;
        b = vf[k][e];
        q.push_back('{dst: i, idx: e, data: sub ? a - b : a + b, due: c + 1 + e + LAT});
      end
    end
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((cyc <= busy_hi || q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 3000), 64'd1);
  endtask
  // per-cycle scoreboard: busy window, reject pulses, and every result's tag, data and arrival cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy", 64'(bus.o_busy), 64'(model_busy(cyc)));
      chk("reject", 64'(bus.o_reject), 64'(rej_map.exists(cyc)));
      if (bus.o_wr_valid) begin
        if (q.size() == 0) chk("spurious_wr_valid", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("wr_reg", 64'(bus.o_wr_reg), 64'(e.dst));
          chk("wr_idx", 64'(bus.o_wr_idx), 64'(e.idx));
          chk("result", bus.o_result, e.data);
          chk("result_cycle", 64'(cyc), 64'(e.due));
          got.push_back(bus.o_result);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        chk("missing_wr_valid", 64'd0, 64'd1);
        void'(q.pop_front());
      end
    end
  end
  initial begin
    int n;
    logic [6:0] ins;
    bus.i_start = 1'b0;
    bus.i_instr = '0;
    bus.i_i = '0;
    bus.i_j = '0;
    bus.i_k = '0;
    bus.i_vl = '0;
    bus.i_sj = '0;
    for (int r = 0; r < NUM_VREG; r++) for (int e = 0; e < 128; e++) vf[r][e] = '0;
    vf[0][0] = 64'd7;
    vf[1][0] = 64'd1; vf[1][1] = 64'd2; vf[1][2] = 64'd3; vf[1][3] = '1;
    vf[2][0] = 64'd10; vf[2][1] = 64'd20; vf[2][2] = 64'd30; vf[2][3] = 64'd1;
    rows[0] = '{VADD, 3, 1, 2, 4, 64'd0, 4, '{64'd11, 64'd22, 64'd33, 64'd0}};
    rows[1] = '{SSUB, 1, 0, 0, 1, 64'd5, 1, '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 64'd0}};
    rows[2] = '{SADD, 5, 0, 2, 2, 64'd100, 2, '{64'd110, 64'd120, 64'd0, 64'd0}};
    rows[3] = '{VSUB, 7, 2, 1, 3, 64'd0, 3, '{64'd9, 64'd18, 64'd27, 64'd0}};
    rows[4] = '{VADD, 4, 1, 2, 0, 64'd0, 0, '{64'd0, 64'd0, 64'd0, 64'd0}};
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_wr_valid", 64'(bus.o_wr_valid), 64'd0);
    chk("rst_result", bus.o_result, 64'd0);
    chk("rst_rd_idx", 64'(bus.o_rd_idx), 64'd0);
    chk("rst_reject", 64'(bus.o_reject), 64'd0);
    rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      got.delete();
      do_start(rows[r].instr, rows[r].i, rows[r].j, rows[r].k, rows[r].vl, rows[r].sj);
      wait_idle();
      chk($sformatf("row%0d_count", r), 64'(got.size()), 64'(rows[r].n));
      for (int e = 0; e < rows[r].n && e < got.size(); e++)
        chk($sformatf("row%0d_e%0d", r, e), got[e], rows[r].exp[e]);
    end
    got.delete();
    do_start(VADD, 3, 1, 2, 4, 64'd0);
    @(negedge clk);
    do_start(SADD, 6, 0, 0, 5, 64'd9);
    wait_idle();
    chk("busy_start_count", 64'(got.size()), 64'd4);
    for (int e = 0; e < 4 && e < got.size(); e++) chk($sformatf("busy_start_e%0d", e), got[e], rows[0].exp[e]);
    do_start(7'b0000000, 1, 1, 1, 3, 64'd0);
    @(negedge clk);
    chk("illegal_busy", 64'(bus.o_busy), 64'd0);
    for (int r = 3; r < 7; r++) for (int e = 0; e < 128; e++) vf[r][e] = {$urandom, $urandom};
    got.delete();
    do_start(VSUB, 4, 5, 6, 127, 64'd0);
    wait_idle();
    chk("vl127_count", 64'(got.size()), 64'd127);
    do_start(VADD, 2, 3, 4, 20, 64'd0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.o_busy), 64'd0);
    chk("midrst_wr_valid", 64'(bus.o_wr_valid), 64'd0);
    chk("midrst_result", bus.o_result, 64'd0);
    q.delete();
    rej_map.delete();
    busy_hi = -1;
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    do_start(SADD, 1, 0, 3, 2, 64'd1000);
    wait_idle();
    chk("post_rst_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) chk("post_rst_e1", got[1], 64'd1000 + vf[3][1]);
    got.delete();
    do_start(VADD, 6, 1, 2, 3, 64'd0);
    n = 0;
    while (cyc != busy_hi && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_wait", 64'(n < 100), 64'd1);
    do_start(VSUB, 2, 4, 5, 3, 64'd0);
    wait_idle();
    chk("b2b_count", 64'(got.size()), 64'd6);
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if (!model_busy(cyc) && !model_busy(cyc + 1))
        for (int e = 0; e < 16; e++) vf[$urandom_range(0, 7)][e] = {$urandom, $urandom};
      ins = $urandom_range(0, 7) == 0 ? 7'($urandom) : SADD + 7'($urandom_range(0, 3));
      do_start(ins, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 12), {$urandom, $urandom});
    end
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
